// File: rtl/bayer_window_5tap_if.sv
// rtl/bayer_window_5tap_if.sv - raster pixel input and 5-tap window output bundle
interface bayer_window_5tap_if #(
    parameter int pixelBitWidth = 12
);
    logic [pixelBitWidth-1:0] pix_in;
    logic                     pix_valid;
    logic                     sof;
    logic [pixelBitWidth-1:0] h_m2, h_m1, h_p1, h_p2;
    logic [pixelBitWidth-1:0] v_m2, v_m1, v_p1, v_p2;
    logic [pixelBitWidth-1:0] c_out;
    logic                     out_valid;
    logic                     frame_done;
    logic                     sof_err;

    modport master (
        output pix_in, pix_valid, sof,
        input  h_m2, h_m1, h_p1, h_p2, v_m2, v_m1, v_p1, v_p2, c_out,
        input  out_valid, frame_done, sof_err
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output h_m2, h_m1, h_p1, h_p2, v_m2, v_m1, v_p1, v_p2, c_out,
        output out_valid, frame_done, sof_err
    );
endinterface

// File: rtl/bayer_window_5tap.sv
// rtl/bayer_window_5tap.sv - raster-to-window generator producing horizontal and vertical 5-tap sets
module bayer_window_5tap #(
    parameter int pixelBitWidth = 12,
    parameter int imgWidth      = 640,
    parameter int imgHeight     = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    bayer_window_5tap_if.slave    bus
);
    localparam int CW = $clog2(imgWidth);
    localparam int RW = $clog2(imgHeight);

    typedef logic [pixelBitWidth-1:0] pix_t;
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, state_n;
    logic [CW-1:0] col, pos_c;
    logic [RW-1:0] row, pos_r;
    logic        restart, accept, last_pix, emit;

    pix_t        lb [4][imgWidth];
    pix_t [4:0]  cv;
    pix_t [3:0]  d1, d2;
    pix_t [3:0]  hsr;

    // A sof always wins: the pixel carrying it is (0,0) regardless of state.
    always_comb begin
        state_n  = state;
        restart  = bus.pix_valid & bus.sof;
        accept   = bus.pix_valid & (restart | (state == ACTIVE));
        pos_c    = restart ? '0 : col;
        pos_r    = restart ? '0 : row;
        last_pix = accept & (pos_r == RW'(imgHeight - 1)) & (pos_c == CW'(imgWidth - 1));
        emit     = accept & (pos_r >= RW'(4)) & (pos_c >= CW'(4));
        if (restart) state_n = ACTIVE;
        if (last_pix) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_c == CW'(imgWidth - 1)) begin
                col <= '0;
                row <= last_pix ? '0 : pos_r + 1'b1;
            end else begin
                col <= pos_c + 1'b1;
                row <= pos_r;
            end
        end
    end

    // cv[k] is row r-k at the current column; cv[2] is the row of the center.
    always_comb begin
        cv[0] = bus.pix_in;
        for (int k = 1; k < 5; k++) cv[k] = lb[k-1][pos_c];
    end

    // The center row travels through hsr; the delay line carries the other four rows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][pos_c] <= bus.pix_in;
            for (int k = 1; k < 4; k++) lb[k][pos_c] <= lb[k-1][pos_c];
            d1  <= {cv[4], cv[3], cv[1], cv[0]};
            d2  <= d1;
            hsr <= {hsr[2:0], cv[2]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.sof_err    <= 1'b0;
            bus.h_m2       <= '0;
            bus.h_m1       <= '0;
            bus.h_p1       <= '0;
            bus.h_p2       <= '0;
            bus.v_m2       <= '0;
            bus.v_m1       <= '0;
            bus.v_p1       <= '0;
            bus.v_p2       <= '0;
            bus.c_out      <= '0;
        end else begin
            bus.out_valid  <= emit;
            bus.frame_done <= last_pix;
            bus.sof_err    <= restart & (state == ACTIVE);
            if (emit) begin
                bus.h_m2  <= hsr[3];
                bus.h_m1  <= hsr[2];
                bus.c_out <= hsr[1];
                bus.h_p1  <= hsr[0];
                bus.h_p2  <= cv[2];
                bus.v_m2  <= d2[3];
                bus.v_m1  <= d2[2];
                bus.v_p1  <= d2[1];
                bus.v_p2  <= d2[0];
            end
        end
    end
endmodule

// File: tb/tb_bayer_window_5tap.sv
// tb/tb_bayer_window_5tap.sv - scoreboard bench for bayer_window_5tap on an 8x6 frame
module tb_bayer_window_5tap;
    localparam int W = 8;
    localparam int H = 6;
    localparam int PW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bayer_window_5tap_if #(.pixelBitWidth(PW)) bus ();

    bayer_window_5tap #(.pixelBitWidth(PW), .imgWidth(W), .imgHeight(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0][PW-1:0] h;
        logic [4:0][PW-1:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_fd = 1'b0;
    logic exp_se = 1'b0;
    int   out_cnt = 0;
    logic [PW-1:0] first_c = '0;
    logic [PW-1:0] last_c = '0;

    bit   m_active = 0;
    int   m_r = 0, m_c = 0;
    logic [PW-1:0] img [H][W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position tracking plus window lookup in the stored image.
    task automatic drive(input logic v, input logic s, input logic [PW-1:0] p);
        exp_t e;
        @(negedge clk);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        exp_fd = 1'b0;
        exp_se = 1'b0;
        if (v && s) out_cnt = 0;
        if (v && (m_active || s)) begin
            if (s) begin
                if (m_active) exp_se = 1'b1;
                m_r = 0;
                m_c = 0;
                m_active = 1;
            end
            img[m_r][m_c] = p;
            if (m_r >= 4 && m_c >= 4) begin
                for (int k = 0; k < 5; k++) begin
                    e.h[k] = img[m_r-2][m_c-4+k];
                    e.v[k] = img[m_r-4+k][m_c-2];
                end
                q.push_back(e);
            end
            if (m_r == H-1 && m_c == W-1) begin
                exp_fd = 1'b1;
                m_active = 0;
            end else if (m_c == W-1) begin
                m_c = 0;
                m_r++;
            end else begin
                m_c++;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        exp_fd = 1'b0;
        exp_se = 1'b0;
        q.delete();
        m_active = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends pixels in raster order, stopping just before (stop_r, stop_c).
    task automatic send_frame(input logic [PW-1:0] ofs, input bit rnd, input bit gaps,
                              input int stop_r, input int stop_c);
        logic [PW-1:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (gaps) while ($urandom_range(0, 2) != 0) idle(1);
                p = rnd ? PW'($urandom) : ofs + PW'({r[3:0], c[3:0]});
                drive(1'b1, (r == 0 && c == 0), p);
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [PW-1:0] ofs);
        idle(2);
        chk({tag, "_count"}, out_cnt, (H-4)*(W-4));
        chk({tag, "_first_c"}, first_c, ofs + 12'h22);
        chk({tag, "_last_c"}, last_c, ofs + 12'h35);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_pulses", {bus.frame_done, bus.sof_err}, 0);
            chk("rst_taps", |{bus.h_m2, bus.h_m1, bus.h_p1, bus.h_p2, bus.c_out,
                              bus.v_m2, bus.v_m1, bus.v_p1, bus.v_p2}, 0);
        end else begin
            chk("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (bus.out_valid) begin
                    chk("h_m2", bus.h_m2, e.h[0]);
                    chk("h_m1", bus.h_m1, e.h[1]);
                    chk("c_out", bus.c_out, e.h[2]);
                    chk("h_p1", bus.h_p1, e.h[3]);
                    chk("h_p2", bus.h_p2, e.h[4]);
                    chk("v_m2", bus.v_m2, e.v[0]);
                    chk("v_m1", bus.v_m1, e.v[1]);
                    chk("v_c", e.v[2], e.h[2]);
                    chk("v_p1", bus.v_p1, e.v[3]);
                    chk("v_p2", bus.v_p2, e.v[4]);
                end
            end
            if (bus.out_valid) begin
                out_cnt++;
                if (out_cnt == 1) first_c = bus.c_out;
                last_c = bus.c_out;
            end
            chk("frame_done", bus.frame_done, exp_fd);
            chk("sof_err", bus.sof_err, exp_se);
        end
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        bus.pix_in = '0;
        do_reset(3);

        send_frame(12'h000, 0, 0, H, 0);
        check_frame("contig", 12'h000);

        send_frame(12'h000, 0, 1, H, 0);
        check_frame("stalled", 12'h000);

        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, PW'($urandom));
        send_frame(12'h000, 0, 0, H, 0);
        check_frame("presof", 12'h000);

        send_frame(12'h000, 0, 0, 4, 6);
        send_frame(12'h080, 0, 0, H, 0);
        check_frame("abort", 12'h080);

        send_frame(12'h000, 0, 0, 5, 2);
        do_reset(2);
        send_frame(12'h000, 0, 0, H, 0);
        check_frame("midrst", 12'h000);

        send_frame(12'h000, 0, 0, H, 0);
        send_frame(12'h000, 0, 0, H, 0);
        check_frame("b2b", 12'h000);

        send_frame(12'h000, 1, 1, H, 0);
        idle(2);
        chk("rand_count", out_cnt, (H-4)*(W-4));

        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
